perf_monitor: RTL and testbench
===============================

// Module: perf_monitor
// PURPOSE
//  Synthesizable performance/termination monitor inside the pipelined core, next to the datapath.
//  Counts cycles, retired instructions, stall cycles and flushes while the program runs.
//  Freezes all counts when the program's terminating store occurs, then computes CPI x100
//  with a bit-serial divider. Counts and CPI are readable through a select-based read port.
// PARAMETERS
//  CNT_W      32   counter width; every counter saturates at all-ones
//  TERM_ADDR  100  data address whose store terminates the run (freeze trigger)
// PORTS
//  clk          in   1      core clock; all state updates on rising edge
//  reset        in   1      asynchronous, active-low (0 = reset asserted)
//  clear        in   1      synchronous: zero all counters, abort divider, return to RUN
//  retire_valid in   1      WB stage holds a real (non-bubble) instruction this cycle
//  stall_f      in   1      fetch stage stalled this cycle
//  flush_e      in   1      execute stage flushed this cycle
//  mem_write    in   1      MEM stage store enable
//  data_adr     in   32     MEM stage store address
//  rd_sel       in   3      read select: 0 cyc, 1 instret, 2 stall, 3 flush, 4 cpi_x100
//  rd_data      out  CNT_W  selected value, combinational from registers; sel 5-7 -> 0
//  done         out  1      1 while state is FROZEN or DIV
//  cpi_valid    out  1      1 once cpi_x100 holds the final result
// BEHAVIOUR
//  - Reset (reset=0, any time, including mid-division): all counters, the quotient, done and
//    cpi_valid go to 0 immediately; state = RUN. rd_data then reads 0 for every select.
//  - States: RUN -> DIV -> FROZEN.
//    RUN: each edge, cyc+=1; instret+=retire_valid; stall+=stall_f; flush+=flush_e.
//    Term = mem_write && data_adr==TERM_ADDR. The term cycle's increments ARE included,
//    and the same edge moves the state to DIV.
//    DIV: counters hold. Dividend = cyc*100 (CNT_W+7 bits); divisor = instret.
//      Restoring division, one quotient bit per edge, CNT_W+7 edges in total.
//      On the last edge the result is written to cpi_x100 and the state moves to FROZEN.
//      cpi_valid=1 on that edge, i.e. CNT_W+7 edges after the term edge (39 by default).
//      If instret==0: cpi_x100=0, cpi_valid=1 and state FROZEN on the first DIV edge.
//      If the quotient exceeds CNT_W bits, cpi_x100 = all-ones.
//    FROZEN: everything holds; further term stores are ignored.
//  - Saturation: a counter at all-ones stays at all-ones and never wraps.
//  - clear=1 in any state: the next edge zeroes all counters, cpi_x100 and cpi_valid;
//    state = RUN; that cycle's events are not counted. clear wins over a simultaneous term store.
//  - A store to any other address has no effect on state.
//  - Inputs are sampled on the rising edge only; no combinational path from inputs to outputs
//    except rd_sel -> rd_data.
// TESTING
//  1. reset=0 mid-run with cyc=57 -> rd_data=0 for all sel, done=0 while reset=0; counting restarts at release.
//  2. 20 RUN cycles, retire_valid on 10, stall_f on 4, flush_e on 2, then a store to 100 in cycle 21 ->
//     cyc=21, instret=10 (+1 if retire_valid in cycle 21), stall=4, flush=2, done=1.
//  3. Freeze with cyc=50, instret=40 -> cpi_valid rises exactly 39 edges after the term edge, cpi_x100=125.
//  4. Freeze with instret=0 -> cpi_valid=1 one edge after the term edge, cpi_x100=0.
//  5. CNT_W=8: run 300 cycles -> cyc holds at 255; store to 96 -> no freeze;
//     clear together with a store to 100 -> counters 0, state RUN, done=0.
//  6. clear asserted halfway through DIV -> next edge cpi_valid=0, done=0, counters 0, counting resumes.

Source files
------------

// File: rtl/perf_monitor.sv
// perf_monitor
//   Performance / termination monitor sitting beside the pipelined datapath.
//   While the program runs it counts cycles, retired instructions, fetch stall
//   cycles and execute flushes. The terminating store (mem_write to TERM_ADDR)
//   freezes every count, after which a bit-serial restoring divider computes
//   CPI x100 = cyc*100 / instret, one quotient bit per clock.
//
// Ports
//   clk          core clock, rising edge
//   reset        asynchronous, active-low
//   clear        synchronous: zero counters and result, abort divider, back to RUN
//   retire_valid WB stage holds a real instruction
//   stall_f      fetch stage stalled
//   flush_e      execute stage flushed
//   mem_write    MEM stage store enable
//   data_adr     MEM stage store address
//   rd_sel       0 cyc, 1 instret, 2 stall, 3 flush, 4 cpi_x100, 5-7 read zero
//   rd_data      selected register value (combinational from rd_sel only)
//   done         high in DIV and FROZEN
//   cpi_valid    high once cpi_x100 holds the final quotient
module perf_monitor #(
   parameter int          CNT_W     = 32,
   parameter logic [31:0] TERM_ADDR = 32'd100
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             retire_valid,
   input  logic             stall_f,
   input  logic             flush_e,
   input  logic             mem_write,
   input  logic [31:0]      data_adr,
   input  logic [2:0]       rd_sel,
   output logic [CNT_W-1:0] rd_data,
   output logic             done,
   output logic             cpi_valid
);

   // Dividend cyc*100 needs 7 extra bits (100 < 2^7).
   localparam int DW = CNT_W + 7;
   localparam int IW = $clog2(DW);

   localparam logic [1:0] RUN    = 2'd0;
   localparam logic [1:0] DIV    = 2'd1;
   localparam logic [1:0] FROZEN = 2'd2;

   localparam logic [CNT_W-1:0] MAX      = '1;
   localparam logic [DW-1:0]    HUNDRED  = DW'(100);
   localparam logic [IW-1:0]    LAST_IDX = IW'(DW - 1);

   logic [1:0]       state;
   logic [CNT_W-1:0] cyc, instret, stall_cnt, flush_cnt, cpi_x100;
   logic [CNT_W-1:0] rem;
   logic [DW-1:0]    quo;
   logic [IW-1:0]    bit_idx;

   logic [DW-1:0]    dvd;
   logic [CNT_W:0]   rem_sh;
   logic             q_bit;
   logic [CNT_W-1:0] rem_nxt;
   logic [DW-1:0]    quo_nxt;
   logic [CNT_W-1:0] quo_sat;
   logic             term;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
      return (en && v != MAX) ? v + 1'b1 : v;
   endfunction

   assign term = mem_write && (data_adr == TERM_ADDR);

   // Counters hold during DIV, so the dividend is formed straight from cyc
   // and walked MSB-first by bit_idx instead of being shifted out of a copy.
   assign dvd = {7'd0, cyc} * HUNDRED;

   // One restoring step. The remainder stays below instret, so after the
   // subtract it fits CNT_W bits and modular subtraction on the low bits is exact.
   always_comb begin
      rem_sh           = {rem, dvd[bit_idx]};
      q_bit            = rem_sh >= {1'b0, instret};
      rem_nxt          = rem_sh[CNT_W-1:0] - (q_bit ? instret : '0);
      quo_nxt          = quo;
      quo_nxt[bit_idx] = q_bit;
      quo_sat          = (quo_nxt[DW-1:CNT_W] != '0) ? MAX : quo_nxt[CNT_W-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= RUN;
         cyc       <= '0;
         instret   <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
         cpi_x100  <= '0;
         cpi_valid <= 1'b0;
         rem       <= '0;
         quo       <= '0;
         bit_idx   <= '0;
      end else if (clear) begin
         // Clear beats a same-cycle terminating store; this cycle is not counted.
         state     <= RUN;
         cyc       <= '0;
         instret   <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
         cpi_x100  <= '0;
         cpi_valid <= 1'b0;
         rem       <= '0;
         quo       <= '0;
         bit_idx   <= '0;
      end else begin
         case (state)
            RUN: begin
               // The terminating cycle's own events are still counted.
               cyc       <= sat_inc(cyc, 1'b1);
               instret   <= sat_inc(instret, retire_valid);
               stall_cnt <= sat_inc(stall_cnt, stall_f);
               flush_cnt <= sat_inc(flush_cnt, flush_e);
               if (term) begin
                  state   <= DIV;
                  rem     <= '0;
                  quo     <= '0;
                  bit_idx <= LAST_IDX;
               end
            end
            DIV: begin
               if (instret == '0) begin
                  // Nothing retired: report 0 rather than dividing by zero.
                  cpi_x100  <= '0;
                  cpi_valid <= 1'b1;
                  state     <= FROZEN;
               end else begin
                  rem <= rem_nxt;
                  quo <= quo_nxt;
                  if (bit_idx == '0) begin
                     cpi_x100  <= quo_sat;
                     cpi_valid <= 1'b1;
                     state     <= FROZEN;
                  end else begin
                     bit_idx <= bit_idx - 1'b1;
                  end
               end
            end
            FROZEN: ;
            default: state <= RUN;
         endcase
      end
   end

   assign done = (state == DIV) || (state == FROZEN);

   always_comb begin
      rd_data = '0;
      case (rd_sel)
         3'd0: rd_data = cyc;
         3'd1: rd_data = instret;
         3'd2: rd_data = stall_cnt;
         3'd3: rd_data = flush_cnt;
         3'd4: rd_data = cpi_x100;
         default: rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: a default-width instance (CNT_W=32) and a narrow one
// (CNT_W=8) see the same stimulus. A per-instance event-count model predicts
// counts, freeze, CPI latency and the CPI value; every cycle all read selects
// plus done/cpi_valid are compared.
module tb_perf_monitor;

   logic        clk = 1'b0;
   logic        reset, clear, retire_valid, stall_f, flush_e, mem_write;
   logic [31:0] data_adr;
   logic [2:0]  rd_sel;
   logic [31:0] rd_a;
   logic [7:0]  rd_b;
   logic        done_a, done_b, valid_a, valid_b;

   int n_chk = 0;
   int n_pass = 0;

   perf_monitor u_a (
      .clk(clk), .reset(reset), .clear(clear), .retire_valid(retire_valid),
      .stall_f(stall_f), .flush_e(flush_e), .mem_write(mem_write),
      .data_adr(data_adr), .rd_sel(rd_sel), .rd_data(rd_a),
      .done(done_a), .cpi_valid(valid_a));

   perf_monitor #(.CNT_W(8)) u_b (
      .clk(clk), .reset(reset), .clear(clear), .retire_valid(retire_valid),
      .stall_f(stall_f), .flush_e(flush_e), .mem_write(mem_write),
      .data_adr(data_adr), .rd_sel(rd_sel), .rd_data(rd_b),
      .done(done_b), .cpi_valid(valid_b));

   always #10 clk = ~clk;

   // Reference model: plain event counts per instance, plus edges since termination.
   int     mw[2] = '{32, 8};
   longint m_cyc[2], m_ins[2], m_stl[2], m_fls[2];
   bit     m_run[2];
   int     m_since[2];

   function automatic longint smax(int w);
      return (longint'(1) << w) - 1;
   endfunction

   function automatic longint sinc(longint v, bit en, int w);
      return (en && v < smax(w)) ? v + 1 : v;
   endfunction

   function automatic bit m_valid(int i);
      int lat = (m_ins[i] == 0) ? 1 : mw[i] + 7;
      return !m_run[i] && m_since[i] >= lat;
   endfunction

   function automatic longint m_cpi(int i);
      longint q;
      if (!m_valid(i) || m_ins[i] == 0) return 0;
      q = (m_cyc[i] * 100) / m_ins[i];
      return (q > smax(mw[i])) ? smax(mw[i]) : q;
   endfunction

   function automatic longint exp_rd(int i, int s);
      case (s)
         0: return m_cyc[i];
         1: return m_ins[i];
         2: return m_stl[i];
         3: return m_fls[i];
         4: return m_cpi(i);
         default: return 0;
      endcase
   endfunction

   task automatic m_zero();
      for (int i = 0; i < 2; i++) begin
         m_cyc[i] = 0; m_ins[i] = 0; m_stl[i] = 0; m_fls[i] = 0;
         m_run[i] = 1'b1; m_since[i] = 0;
      end
   endtask

   task automatic m_edge(bit c, bit r, bit s, bit f, bit w, logic [31:0] a);
      for (int i = 0; i < 2; i++) begin
         if (c) begin
            m_cyc[i] = 0; m_ins[i] = 0; m_stl[i] = 0; m_fls[i] = 0;
            m_run[i] = 1'b1; m_since[i] = 0;
         end else if (m_run[i]) begin
            m_cyc[i] = sinc(m_cyc[i], 1'b1, mw[i]);
            m_ins[i] = sinc(m_ins[i], r, mw[i]);
            m_stl[i] = sinc(m_stl[i], s, mw[i]);
            m_fls[i] = sinc(m_fls[i], f, mw[i]);
            if (w && a == 32'd100) begin
               m_run[i] = 1'b0;
               m_since[i] = 0;
            end
         end else if (m_since[i] < 1000) begin
            m_since[i]++;
         end
      end
   endtask

   task automatic chk(string tag, longint act, longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
   endtask

   task automatic chk_all(string tag);
      for (int s = 0; s < 8; s++) begin
         rd_sel = 3'(s);
         #1;
         chk($sformatf("%s_a_sel%0d", tag, s), rd_a, exp_rd(0, s));
         chk($sformatf("%s_b_sel%0d", tag, s), rd_b, exp_rd(1, s));
      end
      chk({tag, "_a_done"}, done_a, !m_run[0]);
      chk({tag, "_b_done"}, done_b, !m_run[1]);
      chk({tag, "_a_valid"}, valid_a, m_valid(0));
      chk({tag, "_b_valid"}, valid_b, m_valid(1));
   endtask

   task automatic step(string tag, bit c, bit r, bit s, bit f, bit w, logic [31:0] a);
      clear = c; retire_valid = r; stall_f = s; flush_e = f; mem_write = w; data_adr = a;
      @(posedge clk);
      m_edge(c, r, s, f, w, a);
      #1;
      chk_all(tag);
   endtask

   task automatic idle(string tag, int n);
      for (int k = 0; k < n; k++) step(tag, 0, 0, 0, 0, 0, 32'd0);
   endtask

   task automatic rnd_step(string tag, bit allow_term);
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'd100 : 32'($urandom_range(90, 110));
      if (!allow_term && a == 32'd100) a = 32'd99;
      step(tag, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a);
   endtask

   // Async reset between edges: everything reads zero while it is held,
   // including across a clock edge.
   task automatic async_reset(string tag);
      reset = 1'b0;
      m_zero();
      #1;
      chk_all(tag);
      @(negedge clk);
      chk_all({tag, "_held"});
      reset = 1'b1;
   endtask

   task automatic rd(input logic [2:0] s, output logic [31:0] va, output logic [7:0] vb);
      rd_sel = s;
      #1;
      va = rd_a;
      vb = rd_b;
   endtask

   logic [31:0] va;
   logic [7:0]  vb;
   int          lat;

   initial begin
      reset = 1'b0; clear = 0; retire_valid = 0; stall_f = 0; flush_e = 0;
      mem_write = 0; data_adr = '0; rd_sel = '0;
      m_zero();
      #3;
      chk_all("rst");
      @(negedge clk);
      reset = 1'b1;

      // Reset in the middle of a run at cyc=57.
      step("t1_clr", 1, 0, 0, 0, 0, 32'd0);
      for (int k = 0; k < 57; k++) rnd_step("t1_run", 1'b0);
      rd(3'd0, va, vb);
      chk("t1_cyc57", va, 57);
      async_reset("t1_rst");
      step("t1_restart", 0, 1, 0, 0, 0, 32'd0);
      rd(3'd0, va, vb);
      chk("t1_cyc_restart", va, 1);

      // Directed counting then termination with a retire in the term cycle.
      step("t2_clr", 1, 0, 0, 0, 0, 32'd0);
      for (int i = 1; i <= 20; i++)
         step("t2_run", 0, i <= 10, (i % 5) == 0, i == 3 || i == 7, 0, 32'd100);
      step("t2_term", 0, 1, 0, 0, 1, 32'd100);
      rd(3'd0, va, vb); chk("t2_cyc", va, 21);
      rd(3'd1, va, vb); chk("t2_instret", va, 11);
      rd(3'd2, va, vb); chk("t2_stall", va, 4);
      rd(3'd3, va, vb); chk("t2_flush", va, 2);
      chk("t2_done", done_a, 1);
      idle("t2_div", 40);
      rd(3'd4, va, vb); chk("t2_cpi", va, 190);

      // cyc=50, instret=40: CPI x100 = 125, latency 39 edges.
      step("t3_clr", 1, 0, 0, 0, 0, 32'd0);
      for (int i = 1; i <= 50; i++) step("t3_run", 0, i <= 40, 0, 0, i == 50, 32'd100);
      lat = 0;
      for (int k = 1; k <= 60 && lat == 0; k++) begin
         step("t3_div", 0, 0, 0, 0, 0, 32'd0);
         if (valid_a) lat = k;
      end
      chk("t3_latency", lat, 39);
      rd(3'd4, va, vb); chk("t3_cpi", va, 125);
      step("t3_term_ignored", 0, 1, 1, 1, 1, 32'd100);

      // Nothing retired: result 0, valid one edge after termination.
      step("t4_clr", 1, 0, 0, 0, 0, 32'd0);
      step("t4_term", 0, 0, 0, 0, 1, 32'd100);
      step("t4_div", 0, 0, 0, 0, 0, 32'd0);
      chk("t4_valid", valid_a, 1);
      rd(3'd4, va, vb); chk("t4_cpi", va, 0);

      // Narrow instance saturates; wrong address ignored; clear beats term.
      step("t5_clr", 1, 0, 0, 0, 0, 32'd0);
      for (int k = 0; k < 300; k++) rnd_step("t5_run", 1'b0);
      rd(3'd0, va, vb); chk("t5_sat", vb, 255);
      step("t5_adr96", 0, 0, 0, 0, 1, 32'd96);
      chk("t5_no_freeze", done_b, 0);
      step("t5_clr_term", 1, 1, 1, 1, 1, 32'd100);
      chk("t5_done", done_b, 0);
      rd(3'd0, va, vb); chk("t5_cyc0", vb, 0);

      // Clear in the middle of the division.
      for (int k = 0; k < 10; k++) rnd_step("t6_run", 1'b0);
      step("t6_term", 0, 1, 0, 0, 1, 32'd100);
      idle("t6_div", 20);
      step("t6_clr", 1, 0, 0, 0, 0, 32'd0);
      chk("t6_valid", valid_a, 0);
      chk("t6_done", done_a, 0);
      step("t6_resume", 0, 1, 0, 0, 0, 32'd0);
      rd(3'd1, va, vb); chk("t6_instret", va, 1);

      // Random runs with occasional clear and reset.
      for (int run = 0; run < 25; run++) begin
         step("rnd_clr", 1, 0, 0, 0, 0, 32'd0);
         for (int k = 0; k < 80; k++) begin
            if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
            else if ($urandom_range(0, 59) == 0) step("rnd_midclr", 1, 0, 0, 0, 1, 32'd100);
            else rnd_step("rnd", 1'b1);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
